lcs_frame_sequencer: RTL and testbench

//  Master-side controller for the LCS answer responder. Walks the LCS address space once per frame.
//  Per byte: present the address, run a req/ack handshake with the responder, capture the returned byte,

---
 rtl/lcs_pkg.sv | 32 +++
 rtl/lcs_sync2.sv | 25 ++
 rtl/lcs_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lcs_frame_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcs_pkg.sv
// Shared types and defaults for the LCS frame sequencer.
// State encoding plus the frame geometry the responder expects.
package lcs_pkg;

  localparam int LCS_FRAME_LEN   = 256;
  localparam int LCS_ADDR_W      = 9;
  localparam int LCS_ACK_TIMEOUT = 255;
  localparam int LCS_DATA_WAIT   = 32;
  localparam int LCS_REQ_LOW_MIN = 32;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    SETTLE,
    RELEASE,
    GAP
  } lcs_state_t;

  function automatic int lcs_max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcs_sync2.sv
// Two-flop synchroniser for a single asynchronous control bit.
// Async active-low reset clears both stages.
module lcs_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lcs_frame_sequencer.sv
// Master-side LCS frame walker: one req/ack handshake per byte,
// captured bytes handed to the serializer one load at a time.
module lcs_frame_sequencer
  import lcs_pkg::*;
#(
  parameter int FRAME_LEN   = LCS_FRAME_LEN,
  parameter int ADDR_W      = LCS_ADDR_W,
  parameter int ACK_TIMEOUT = LCS_ACK_TIMEOUT,
  parameter int DATA_WAIT   = LCS_DATA_WAIT,
  parameter int REQ_LOW_MIN = LCS_REQ_LOW_MIN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  output logic              req,
  input  logic              ack,
  output logic [ADDR_W-1:0] addr_lcs,
  input  logic [7:0]        data_in,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  input  logic              tx_busy,
  output logic              frame_active,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int TMR_MAX =
    lcs_max3(ACK_TIMEOUT, DATA_WAIT, REQ_LOW_MIN);
  localparam int TW = $clog2(TMR_MAX + 1);

  localparam logic [TW-1:0] ACK_TO  = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] DW_LAST = TW'(DATA_WAIT - 1);
  localparam logic [TW-1:0] LOW_MIN = TW'(REQ_LOW_MIN);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  logic w_ack_s;
  logic w_ack_rise;

  lcs_state_t        r_state;
  logic [TW-1:0]     r_tmr;
  logic [7:0]        r_byte;
  logic              r_ack_d;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_tx_data;
  logic              r_tx_load;
  logic              r_active;
  logic              r_done;
  logic              r_to;

  lcs_sync2 u_ack_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ack),
    .o_q (w_ack_s)
  );

  assign w_ack_rise = w_ack_s & ~r_ack_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tmr     <= '0;
      r_byte    <= '0;
      r_ack_d   <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_tx_data <= '0;
      r_tx_load <= 1'b0;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_ack_d   <= w_ack_s;
      r_tx_load <= 1'b0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (frame_start) begin
            r_active <= 1'b1;
            r_addr   <= '0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          r_req   <= 1'b1;
          r_tmr   <= '0;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // a real ack beats a timeout landing on the same cycle
          if (w_ack_rise) begin
            r_tmr   <= '0;
            r_state <= SETTLE;
          end else if (r_tmr == ACK_TO) begin
            r_req   <= 1'b0;
            r_byte  <= FILL_BYTE;
            r_to    <= 1'b1;
            r_tmr   <= '0;
            r_state <= RELEASE;
          end else begin
            r_tmr <= r_tmr + TMR_ONE;
          end
        end
        SETTLE: begin
          if (r_tmr == DW_LAST) begin
            r_byte  <= data_in;
            r_req   <= 1'b0;
            r_tmr   <= '0;
            r_state <= RELEASE;
          end else begin
            r_tmr <= r_tmr + TMR_ONE;
          end
        end
        RELEASE: begin
          if (r_tmr < LOW_MIN) begin
            r_tmr <= r_tmr + TMR_ONE;
          end
          if (!tx_busy) begin
            r_tx_data <= r_byte;
            r_tx_load <= 1'b1;
            r_state   <= GAP;
          end
        end
        GAP: begin
          // timer counts req-low time and saturates at the minimum
          if (r_tmr < LOW_MIN) begin
            r_tmr <= r_tmr + TMR_ONE;
          end
          if (r_tmr >= LOW_MIN && !w_ack_s) begin
            if (r_addr == LAST_ADDR) begin
              r_done   <= 1'b1;
              r_active <= 1'b0;
              r_addr   <= '0;
              r_state  <= IDLE;
            end else begin
              r_addr  <= r_addr + ADDR_ONE;
              r_state <= REQ;
            end
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req          = r_req;
  assign addr_lcs     = r_addr;
  assign tx_data      = r_tx_data;
  assign tx_load      = r_tx_load;
  assign frame_active = r_active;
  assign frame_done   = r_done;
  assign timeout_err  = r_to;

endmodule

// File: tb/tb_lcs_frame_sequencer.sv
// Directed bench for lcs_frame_sequencer with an 8-byte frame,
// a behavioural responder and a simple serializer busy model.
module tb_lcs_frame_sequencer;
  import lcs_pkg::*;

  localparam int FL     = 8;
  localparam int ACK_TO = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       ack = 1'b0;
  logic       tx_busy = 1'b0;
  logic [7:0] data_in = 8'hEE;
  logic       req, tx_load, frame_active, frame_done, timeout_err;
  logic [8:0] addr_lcs;
  logic [7:0] tx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // responder / serializer controls
  int miss_addr = -1;
  int miss_mode = 0;
  bit busy_hold = 1'b0;
  int ser_cnt = 0;
  int ack_fall_cyc = 0;

  // monitor state
  logic [7:0] got[$];
  int         lcyc[$];
  logic [7:0] to_mask = 8'h00;
  int         done_cnt = 0;
  int         viol = 0;
  int         rise_cyc = 0;
  int         rise4 = 0;
  int         hi_len[FL];
  logic       busy_p = 1'b0;
  logic       req_q = 1'b0;
  logic [8:0] addr_q = '0;
  logic [7:0] last_tx = 8'h00;

  typedef struct {
    string       name;
    int          miss_addr;
    int          miss_mode;
    bit          busy_hold;
    bit          mid_start;
    logic [63:0] exp;
    logic [7:0]  exp_to;
  } vec_t;

  vec_t tv[5];

  lcs_frame_sequencer #(.FRAME_LEN(FL)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .req          (req),
    .ack          (ack),
    .addr_lcs     (addr_lcs),
    .data_in      (data_in),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .tx_busy      (tx_busy),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_p <= tx_busy;
  end

  // responder: ack 5 cycles after req, data = addr, unless told otherwise
  initial begin : responder
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (req && rst) begin
        a = addr_lcs[7:0];
        if (miss_mode == 2 && a == 8'(miss_addr)) begin
          repeat (280) @(negedge clk);
          data_in = 8'h33;
          ack = 1'b1;
          repeat (16) @(negedge clk);
          ack = 1'b0;
          ack_fall_cyc = cyc;
        end else if (!(miss_mode == 1 && a == 8'(miss_addr))) begin
          repeat (4) @(negedge clk);
          data_in = a;
          ack = 1'b1;
          repeat (2) @(negedge clk);
          ack = 1'b0;
        end
        while (req) @(negedge clk);
        data_in = 8'hEE;
      end
    end
  end

  // serializer: busy 8 cycles per byte, or 100 after the first if held
  initial begin : serializer
    forever begin
      @(negedge clk);
      if (tx_load && rst) begin
        ser_cnt++;
        tx_busy = 1'b1;
        repeat ((busy_hold && ser_cnt == 1) ? 100 : 8) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      req_q   = 1'b0;
      last_tx = tx_data;
    end else begin
      if (tx_load) begin
        got.push_back(tx_data);
        lcyc.push_back(cyc);
        if (busy_p) viol++;
      end else if (tx_data != last_tx) begin
        viol++;
      end
      last_tx = tx_data;
      if (timeout_err) to_mask |= 8'(1 << addr_lcs[2:0]);
      if (frame_done) done_cnt++;
      if (req && req_q && addr_lcs != addr_q) viol++;
      if (req && !req_q) begin
        rise_cyc = cyc;
        if (addr_lcs == 9'd4) rise4 = cyc;
      end
      if (!req && req_q) hi_len[addr_q[2:0]] = cyc - rise_cyc;
      req_q  = req;
      addr_q = addr_lcs;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    lcyc.delete();
    to_mask  = 8'h00;
    done_cnt = 0;
    viol     = 0;
    rise4    = 0;
    ser_cnt  = 0;
    for (int i = 0; i < FL; i++) hi_len[i] = 0;
  endtask

  task automatic run_frame(input bit mid, output logic mid_act);
    mid_act = 1'b1;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
      @(negedge clk);
      frame_start = mid && (c == 150);
      if (mid && c == 150) mid_act = frame_active;
      @(posedge clk);
    end
    @(negedge clk) frame_start = 1'b0;
    check("frame_done_within_budget", int'(done_cnt > 0), 1);
  endtask

  task automatic check_bytes(input string nm, input logic [63:0] exp);
    check({nm, "_loads"}, got.size(), FL);
    for (int i = 0; i < FL; i++) begin
      check($sformatf("%s_byte%0d", nm, i),
            (i < got.size()) ? int'(got[i]) : -1,
            int'(exp[i*8 +: 8]));
    end
  endtask

  initial begin
    logic mid_act;
    bit   found;

    #3 rst = 1'b0;
    #1;
    check("rst_req", int'(req), 0);
    check("rst_addr", int'(addr_lcs), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_tx_load", int'(tx_load), 0);
    check("rst_active", int'(frame_active), 0);
    check("rst_done", int'(frame_done), 0);
    check("rst_timeout", int'(timeout_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    tv[0] = '{"healthy", -1, 0, 1'b0, 1'b0,
              64'h0706050403020100, 8'h00};
    tv[1] = '{"noack3", 3, 1, 1'b0, 1'b0,
              64'h07060504FF020100, 8'h08};
    tv[2] = '{"lateack3", 3, 2, 1'b0, 1'b0,
              64'h07060504FF020100, 8'h08};
    tv[3] = '{"busyhold", -1, 0, 1'b1, 1'b0,
              64'h0706050403020100, 8'h00};
    tv[4] = '{"midstart", -1, 0, 1'b0, 1'b1,
              64'h0706050403020100, 8'h00};

    for (int v = 0; v < 5; v++) begin
      clear_mon();
      miss_addr = tv[v].miss_addr;
      miss_mode = tv[v].miss_mode;
      busy_hold = tv[v].busy_hold;
      run_frame(tv[v].mid_start, mid_act);
      repeat (60) @(negedge clk);
      check_bytes(tv[v].name, tv[v].exp);
      check({tv[v].name, "_timeouts"}, int'(to_mask), int'(tv[v].exp_to));
      check({tv[v].name, "_done_cnt"}, done_cnt, 1);
      check({tv[v].name, "_active_end"}, int'(frame_active), 0);
      check({tv[v].name, "_protocol"}, viol, 0);
      if (tv[v].miss_mode != 0)
        check({tv[v].name, "_req_hi_len"},
              int'(hi_len[3] >= ACK_TO && hi_len[3] <= ACK_TO + 1), 1);
      if (tv[v].miss_mode == 2)
        check({tv[v].name, "_req4_after_ack_low"},
              int'(rise4 >= ack_fall_cyc + 2), 1);
      if (tv[v].busy_hold)
        check({tv[v].name, "_stall"},
              int'(lcyc.size() >= 2 && lcyc[1] - lcyc[0] >= 100), 1);
      if (tv[v].mid_start)
        check({tv[v].name, "_active_at_pulse"}, int'(mid_act), 1);
    end

    // reset while req is high at address 5
    clear_mon();
    miss_addr = -1;
    miss_mode = 0;
    busy_hold = 1'b0;
    found = 1'b0;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      found = req && addr_lcs == 9'd5;
    end
    check("midrst_reached_addr5", int'(found), 1);
    #2 rst = 1'b0;
    #1;
    check("midrst_req", int'(req), 0);
    check("midrst_addr", int'(addr_lcs), 0);
    check("midrst_active", int'(frame_active), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    clear_mon();
    run_frame(1'b0, mid_act);
    repeat (60) @(negedge clk);
    check_bytes("after_rst", 64'h0706050403020100);
    check("after_rst_done_cnt", done_cnt, 1);
    check("after_rst_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
